// File: rtl/dcache_req_arb.sv
// Two-port arbiter and sequencer for the single data-cache request channel.
// Port 0 is the MEM-stage path (flushable); port 1 is an auxiliary requester.
module dcache_req_arb #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        p0_valid_i,
   input  logic        p0_we_i,
   input  logic [3:0]  p0_sel_i,
   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_wdata_i,
   output logic        p0_ready_o,
   output logic        p0_rvalid_o,
   output logic [31:0] p0_rdata_o,
   input  logic        p1_valid_i,
   input  logic        p1_we_i,
   input  logic [3:0]  p1_sel_i,
   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_wdata_i,
   output logic        p1_ready_o,
   output logic        p1_rvalid_o,
   output logic [31:0] p1_rdata_o,
   output logic        cache_ce_o,
   output logic        cache_we_o,
   output logic [3:0]  cache_sel_o,
   output logic [31:0] cache_addr_o,
   output logic [31:0] cache_data_o,
   input  logic        addr_ok_i,
   input  logic        data_ok_i,
   input  logic [31:0] cache_rdata_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT   = 2'd2,
      CANCEL = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               owner_q;
   logic               we_q;
   logic [3:0]         sel_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic               p0_rvalid_q, p1_rvalid_q;
   logic [31:0]        p0_rdata_q, p1_rdata_q;

   logic               gnt0, gnt1;
   logic               eff0;
   logic               kill;
   logic               rsp;

   // Arbitration, starvation tracking and transaction sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      rsp     = 1'b0;
      eff0    = p0_valid_i & ~flush_i;
      kill    = flush_i & ~owner_q;
      unique case (state_q)
         IDLE: begin
            gnt1 = p1_valid_i & (~eff0 | (cnt_q >= CNT_W'(STARVE_LIMIT)));
            gnt0 = eff0 & ~gnt1;
            if (gnt0 | gnt1) begin
               state_d = REQ;
            end
            if (p1_valid_i & ~gnt1) begin
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end
         REQ: begin
            if (addr_ok_i) begin
               if (data_ok_i) begin
                  state_d = IDLE;
                  rsp     = ~kill;
               end else begin
                  state_d = kill ? CANCEL : WAIT;
               end
            end else if (kill) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (data_ok_i) begin
               state_d = IDLE;
               rsp     = ~kill;
            end else if (kill) begin
               state_d = CANCEL;
            end
         end
         CANCEL: begin
            if (data_ok_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (gnt0 | gnt1) begin
            owner_q <= gnt1;
            we_q    <= gnt1 ? p1_we_i    : p0_we_i;
            sel_q   <= gnt1 ? p1_sel_i   : p0_sel_i;
            addr_q  <= gnt1 ? p1_addr_i  : p0_addr_i;
            wdata_q <= gnt1 ? p1_wdata_i : p0_wdata_i;
         end
         p0_rvalid_q <= rsp & ~owner_q;
         p1_rvalid_q <= rsp & owner_q;
         // Store completions return zero data rather than whatever the cache drives.
         if (rsp & ~owner_q) begin
            p0_rdata_q <= we_q ? 32'd0 : cache_rdata_i;
         end
         if (rsp & owner_q) begin
            p1_rdata_q <= we_q ? 32'd0 : cache_rdata_i;
         end
      end
   end

   assign p0_ready_o   = gnt0;
   assign p1_ready_o   = gnt1;
   assign p0_rvalid_o  = p0_rvalid_q;
   assign p1_rvalid_o  = p1_rvalid_q;
   assign p0_rdata_o   = p0_rdata_q;
   assign p1_rdata_o   = p1_rdata_q;
   assign cache_ce_o   = (state_q == REQ);
   assign cache_we_o   = we_q;
   assign cache_sel_o  = sel_q;
   assign cache_addr_o = addr_q;
   assign cache_data_o = wdata_q;
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_req_arb.sv
// Directed, table-driven bench for dcache_req_arb; port 0 issues a fixed load,
// port 1 a fixed store, and each table row is one clock cycle.
module tb_dcache_req_arb;

   localparam logic [31:0] P0_ADDR  = 32'h0000_1000;
   localparam logic [31:0] P0_WDATA = 32'hA5A5_A5A5;
   localparam logic [3:0]  P0_SEL   = 4'b1111;
   localparam logic [31:0] P1_ADDR  = 32'h0000_2004;
   localparam logic [31:0] P1_WDATA = 32'h1234_5678;
   localparam logic [3:0]  P1_SEL   = 4'b0011;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        p0_valid_i, p0_we_i;
   logic [3:0]  p0_sel_i;
   logic [31:0] p0_addr_i, p0_wdata_i;
   logic        p0_ready_o, p0_rvalid_o;
   logic [31:0] p0_rdata_o;
   logic        p1_valid_i, p1_we_i;
   logic [3:0]  p1_sel_i;
   logic [31:0] p1_addr_i, p1_wdata_i;
   logic        p1_ready_o, p1_rvalid_o;
   logic [31:0] p1_rdata_o;
   logic        cache_ce_o, cache_we_o;
   logic [3:0]  cache_sel_o;
   logic [31:0] cache_addr_o, cache_data_o;
   logic        addr_ok_i, data_ok_i;
   logic [31:0] cache_rdata_i;
   logic        busy_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dcache_req_arb #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .p0_valid_i(p0_valid_i), .p0_we_i(p0_we_i), .p0_sel_i(p0_sel_i),
      .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
      .p0_ready_o(p0_ready_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
      .p1_valid_i(p1_valid_i), .p1_we_i(p1_we_i), .p1_sel_i(p1_sel_i),
      .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
      .p1_ready_o(p1_ready_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
      .cache_ce_o(cache_ce_o), .cache_we_o(cache_we_o), .cache_sel_o(cache_sel_o),
      .cache_addr_o(cache_addr_o), .cache_data_o(cache_data_o),
      .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .cache_rdata_i(cache_rdata_i),
      .busy_o(busy_o)
   );

   typedef struct {
      logic        rst_v, fl, v0, v1, aok, dok;
      logic [31:0] crd;
      logic        r0, r1, rv0, rv1;
      logic [31:0] rd;
      logic        ce, own, busy;
   } row_t;

   row_t vec[$];

   function automatic row_t mk(input logic rst_v, fl, v0, v1, aok, dok,
                               input logic [31:0] crd,
                               input logic r0, r1, rv0, rv1,
                               input logic [31:0] rd,
                               input logic ce, own, busy);
      row_t r;
      r.rst_v = rst_v; r.fl = fl; r.v0 = v0; r.v1 = v1; r.aok = aok; r.dok = dok;
      r.crd = crd; r.r0 = r0; r.r1 = r1; r.rv0 = rv0; r.rv1 = rv1; r.rd = rd;
      r.ce = ce; r.own = own; r.busy = busy;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      rst = 1'b0; flush_i = 1'b0;
      p0_valid_i = 1'b0; p0_we_i = 1'b0; p0_sel_i = P0_SEL; p0_addr_i = P0_ADDR; p0_wdata_i = P0_WDATA;
      p1_valid_i = 1'b0; p1_we_i = 1'b1; p1_sel_i = P1_SEL; p1_addr_i = P1_ADDR; p1_wdata_i = P1_WDATA;
      addr_ok_i = 1'b0; data_ok_i = 1'b0; cache_rdata_i = '0;

      //                rst fl v0 v1 aok dok crd            r0 r1 rv0 rv1 rd            ce own busy
      vec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      // port-0 load with a wait state
      vec.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 1, 32'hDEADBEEF,   0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 0, 32'hDEADBEEF,   0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      // port-1 store, zero-wait cache; rdata must read back as zero
      vec.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0,          0, 1, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 1, 1, 32'hFFFFFFFF,   0, 0, 0, 0, 32'h0,          1, 1, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 32'h0,          0, 0, 0));
      // flush in REQ before addr_ok drops the request
      vec.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      // flush in WAIT -> CANCEL, late data_ok swallowed, then a new grant
      vec.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 0, 1));
      vec.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 1, 0, 0, 1, 32'h00000055,   0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 1, 1, 32'hCAFEF00D,   0, 0, 0, 0, 32'h0,          1, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 0, 32'hCAFEF00D,   0, 0, 0));
      // flush in WAIT with port 1 as owner is ignored
      vec.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0,          0, 1, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 1, 1));
      vec.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 1, 32'h00000077,   0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 32'h0,          0, 0, 0));
      // flush coincident with data_ok completes silently
      vec.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 0, 1));
      vec.push_back(mk(1, 1, 0, 0, 0, 1, 32'h00000099,   0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      // flush masks a port-0 request in IDLE
      vec.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      // reset during WAIT, then a stale data_ok
      vec.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          1, 0, 1));
      vec.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 1));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 0, 1, 32'h00000011,   0, 0, 0, 0, 32'h0,          0, 0, 0));
      vec.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          0, 0, 0));

      repeat (2) @(posedge clk);

      for (int i = 0; i < vec.size(); i++) begin
         #1;
         rst = vec[i].rst_v; flush_i = vec[i].fl;
         p0_valid_i = vec[i].v0; p1_valid_i = vec[i].v1;
         addr_ok_i = vec[i].aok; data_ok_i = vec[i].dok; cache_rdata_i = vec[i].crd;
         @(negedge clk);
         chk($sformatf("row%0d p0_ready", i), 32'(p0_ready_o), 32'(vec[i].r0));
         chk($sformatf("row%0d p1_ready", i), 32'(p1_ready_o), 32'(vec[i].r1));
         chk($sformatf("row%0d p0_rvalid", i), 32'(p0_rvalid_o), 32'(vec[i].rv0));
         chk($sformatf("row%0d p1_rvalid", i), 32'(p1_rvalid_o), 32'(vec[i].rv1));
         chk($sformatf("row%0d cache_ce", i), 32'(cache_ce_o), 32'(vec[i].ce));
         chk($sformatf("row%0d busy", i), 32'(busy_o), 32'(vec[i].busy));
         if (vec[i].rv0) chk($sformatf("row%0d p0_rdata", i), p0_rdata_o, vec[i].rd);
         if (vec[i].rv1) chk($sformatf("row%0d p1_rdata", i), p1_rdata_o, vec[i].rd);
         if (vec[i].ce) begin
            chk($sformatf("row%0d cache_addr", i), cache_addr_o, vec[i].own ? P1_ADDR : P0_ADDR);
            chk($sformatf("row%0d cache_data", i), cache_data_o, vec[i].own ? P1_WDATA : P0_WDATA);
            chk($sformatf("row%0d cache_we_sel", i), 32'({cache_we_o, cache_sel_o}),
                32'(vec[i].own ? {1'b1, P1_SEL} : {1'b0, P0_SEL}));
         end
         if (i > 0 && !vec[i-1].rst_v) begin
            chk($sformatf("row%0d reset_regs_a", i), cache_addr_o | cache_data_o, 32'h0);
            chk($sformatf("row%0d reset_regs_b", i), p0_rdata_o | p1_rdata_o | 32'(cache_sel_o), 32'h0);
         end
         @(posedge clk);
      end

      // Starvation: both ports always valid, zero-wait cache; every 5th decision goes to port 1.
      begin
         int k = 0;
         int cyc = 0;
         #1;
         rst = 1'b1; flush_i = 1'b0;
         p0_valid_i = 1'b1; p1_valid_i = 1'b1;
         addr_ok_i = 1'b1; data_ok_i = 1'b1; cache_rdata_i = 32'h0;
         while (k < 10 && cyc < 40) begin
            @(negedge clk);
            if (!busy_o) begin
               chk($sformatf("starve%0d p1_ready", k), 32'(p1_ready_o), 32'((k % 5) == 4));
               chk($sformatf("starve%0d p0_ready", k), 32'(p0_ready_o), 32'((k % 5) != 4));
               k++;
            end
            cyc++;
         end
         tests++;
         if (k < 10) begin
            fails++;
            $display("FAIL starve_timeout: got %0d decisions required 10", k);
         end
         @(posedge clk);
         #1;
         p0_valid_i = 1'b0; p1_valid_i = 1'b0;
         addr_ok_i = 1'b0; data_ok_i = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
